// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command assembler.
// CMD_CHKSUM_EN selects 4-byte frames with a trailing checksum byte.
package cmd_pkg;
`ifdef CMD_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, B1, B2, CHK} rx_state_t;
    localparam int FRAME_BYTES = 4;
`else
    typedef enum logic [1:0] {IDLE, B1, B2} rx_state_t;
    localparam int FRAME_BYTES = 3;
`endif
    typedef enum logic {T_IDLE, T_WAIT} tx_state_t;
    localparam logic [7:0] CHK_SUM = 8'hFF;
endpackage

// File: rtl/cmd_assembler_resp_tx.sv
// Response transmitter: hands one byte at a time to the UART and waits
// for tx_done before accepting the next send request.
module resp_tx
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       resp_send,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_busy
);
    tx_state_t  r_state, w_state_next;
    logic       r_trmt, w_trmt_next;
    logic       r_busy, w_busy_next;
    logic [7:0] r_data, w_data_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= T_IDLE;
            r_trmt  <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_trmt  <= w_trmt_next;
            r_busy  <= w_busy_next;
            r_data  <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_trmt_next  = 1'b0;
        w_busy_next  = r_busy;
        w_data_next  = r_data;
        case (r_state)
            T_IDLE: if (resp_send) begin
                w_data_next  = resp;
                w_trmt_next  = 1'b1;
                w_busy_next  = 1'b1;
                w_state_next = T_WAIT;
            end
            T_WAIT: if (tx_done) begin
                w_busy_next  = 1'b0;
                w_state_next = T_IDLE;
            end
            default: w_state_next = T_IDLE;
        endcase
    end

    assign trmt      = r_trmt;
    assign tx_data   = r_data;
    assign resp_busy = r_busy;
endmodule

// File: rtl/cmd_assembler.sv
// Packs UART bytes into 24-bit command frames with an inter-byte timeout,
// and forwards response bytes to the UART via resp_tx. Macro: CMD_CHKSUM_EN.
module cmd_assembler
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  cmd,
    output logic        clr_rdy,
    output logic [23:0] frame,
    output logic        frame_rdy,
    input  logic        clr_frame_rdy,
    output logic        overrun,
    output logic        timeout,
    output logic        chk_err,
    input  logic        resp_send,
    input  logic [7:0]  resp,
    output logic        resp_busy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done
);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int SH_LSB = (FRAME_BYTES == 4) ? 0 : 8;

    rx_state_t         r_state, w_state_next;
    logic [23:SH_LSB]  r_frame_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic [23:0]       r_frame;
    logic              r_frame_rdy, r_overrun, r_timeout;
    logic              w_complete, w_timeout, w_chk_fail, w_cnt_max;
    logic [23:0]       w_frame_new;

    assign clr_rdy   = rdy;
    assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef CMD_CHKSUM_EN
    logic [7:0] w_sum;
    logic       r_chk_err;
    assign w_sum       = r_frame_sh[23:16] + r_frame_sh[15:8] + r_frame_sh[7:0] + cmd;
    assign w_frame_new = r_frame_sh;
    assign chk_err     = r_chk_err;
`else
    assign w_frame_new = {r_frame_sh, cmd};
    assign chk_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // A byte arriving on the terminal count cycle beats the timeout.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_chk_fail   = 1'b0;
        case (r_state)
            IDLE: if (rdy) w_state_next = B1;
            B1: begin
                if (rdy) w_state_next = B2;
                else if (w_cnt_max) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            B2: begin
                if (rdy) begin
`ifdef CMD_CHKSUM_EN
                    w_state_next = CHK;
`else
                    w_state_next = IDLE;
                    w_complete   = 1'b1;
`endif
                end else if (w_cnt_max) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
`ifdef CMD_CHKSUM_EN
            CHK: begin
                if (rdy) begin
                    w_state_next = IDLE;
                    if (w_sum == CHK_SUM) w_complete = 1'b1;
                    else                  w_chk_fail = 1'b1;
                end else if (w_cnt_max) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_sh  <= '0;
            r_cnt       <= '0;
            r_frame     <= 24'h0;
            r_frame_rdy <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (rdy) begin
                case (r_state)
                    IDLE:    r_frame_sh[23:16] <= cmd;
                    B1:      r_frame_sh[15:8]  <= cmd;
`ifdef CMD_CHKSUM_EN
                    B2:      r_frame_sh[7:0]   <= cmd;
`endif
                    default: ;
                endcase
            end
            if (r_state == IDLE || rdy || w_timeout) r_cnt <= '0;
            else                                     r_cnt <= r_cnt + CNT_W'(1);
            r_overrun <= 1'b0;
            if (w_complete) begin
                r_frame     <= w_frame_new;
                r_frame_rdy <= 1'b1;
                r_overrun   <= r_frame_rdy & ~clr_frame_rdy;
            end else if (clr_frame_rdy) begin
                r_frame_rdy <= 1'b0;
            end
            r_timeout <= w_timeout;
        end
    end

`ifdef CMD_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) r_chk_err <= 1'b0;
        else     r_chk_err <= w_chk_fail;
    end
`endif

    assign frame     = r_frame;
    assign frame_rdy = r_frame_rdy;
    assign overrun   = r_overrun;
    assign timeout   = r_timeout;

    resp_tx u_resp_tx (
        .clk       (clk),
        .rst       (rst),
        .resp_send (resp_send),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_busy (resp_busy)
    );
endmodule
